ram_arbiter: RTL and testbench

//  Sequences the single RAM port among CPUS instruction fetchers and the data path out of the

---
 rtl/ram_arbiter_if.sv | 31 +++
 rtl/ram_arbiter.sv | 134 +++++++++++++
 tb/tb_ram_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - fetch/data requester and RAM port signals of the RAM arbiter
interface ram_arbiter_if #(
  parameter int CPUS = 2
);
  logic [CPUS-1:0]       iREN;
  logic [CPUS-1:0][31:0] iaddr;
  logic [CPUS-1:0]       iwait;
  logic [CPUS-1:0][31:0] iload;
  logic                  dREN;
  logic                  dWEN;
  logic [31:0]           daddr;
  logic [31:0]           dstore;
  logic                  dwait;
  logic [31:0]           dload;
  logic                  ramREN;
  logic                  ramWEN;
  logic [31:0]           ramaddr;
  logic [31:0]           ramstore;
  logic [31:0]           ramload;
  logic [1:0]            ramstate;

  // master: caches, bus controller and RAM model; slave: the arbiter
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single RAM port arbiter: data priority, round-robin fetches, starvation guard
module ram_arbiter #(
  parameter int CPUS         = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic             CLK,
  input logic             nRST,
  ram_arbiter_if.slave    bus
);
  localparam int OW = $clog2(CPUS);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [OW:0]   CPUS_W  = (OW + 1)'(CPUS);
  localparam logic [SW-1:0] LIMIT_W = SW'(STARVE_LIMIT);
  localparam logic [1:0]    RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  logic          data_req;
  logic          any_ireq;
  logic          ram_done;
  logic [OW-1:0] rr_pick;
  logic          rr_found;

  // (base + off) mod CPUS; both operands are below CPUS so one subtraction suffices
  function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base, input logic [OW:0] off);
    logic [OW:0] s;
    s = {1'b0, base} + off;
    if (s >= CPUS_W) s = s - CPUS_W;
    return s[OW-1:0];
  endfunction

  assign data_req = bus.dREN | bus.dWEN;
  assign any_ireq = |bus.iREN;
  assign ram_done = (bus.ramstate == RAM_ACCESS);

  always_comb begin
    rr_pick  = rr_ptr_q;
    rr_found = 1'b0;
    for (int k = 0; k < CPUS; k++) begin
      if (!rr_found && bus.iREN[wrap_add(rr_ptr_q, (OW + 1)'(k))]) begin
        rr_pick  = wrap_add(rr_ptr_q, (OW + 1)'(k));
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      IDLE: begin
        if (data_req && (!any_ireq || starve_cnt_q < LIMIT_W)) begin
          state_d = DGNT;
        end else if (any_ireq) begin
          state_d = IGNT;
          owner_d = rr_pick;
        end
      end
      IGNT: begin
        if (ram_done) begin
          state_d      = IDLE;
          rr_ptr_d     = wrap_add(owner_q, (OW + 1)'(1));
          starve_cnt_d = '0;
        end else if (!bus.iREN[owner_q]) begin
          state_d = IDLE;
        end
      end
      DGNT: begin
        if (ram_done) begin
          state_d = IDLE;
          // only data completions that overtake a waiting fetch count toward the forced grant
          if (!any_ireq) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q < LIMIT_W) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
          end
        end else if (!data_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // outputs decode from the registered state only, so reset clears them immediately
  always_comb begin
    bus.iwait    = '1;
    bus.iload    = '0;
    bus.dwait    = 1'b1;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state_q)
      IGNT: begin
        bus.ramREN         = 1'b1;
        bus.ramaddr        = bus.iaddr[owner_q];
        bus.iwait[owner_q] = !ram_done;
        bus.iload[owner_q] = bus.ramload;
      end
      DGNT: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dWEN ? bus.dstore : 32'd0;
        bus.dwait    = !ram_done;
        bus.dload    = bus.ramload;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed and randomized checks of ram_arbiter against a transaction-level model
module tb_ram_arbiter;
  localparam int CPUS  = 2;
  localparam int LIMIT = 4;
  localparam int DATA  = CPUS;
  localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACCESS = 2'd2, S_ERROR = 2'd3;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  ram_arbiter_if #(.CPUS(CPUS)) bus();
  ram_arbiter #(.CPUS(CPUS), .STARVE_LIMIT(LIMIT)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] ram [32];
  logic [31:0] ref_mem [32];
  int lat = 1, err_left = 0, ram_cnt = 0;
  int comp_who;
  logic [31:0] comp_load, comp_addr, comp_store;

  // RAM: lat enabled cycles per access, optionally preceded by ERROR cycles
  task automatic ram_drive();
    if (!(bus.ramREN || bus.ramWEN)) begin
      ram_cnt = 0;
      bus.ramstate = S_FREE;
    end else if (err_left > 0) begin
      err_left--;
      bus.ramstate = S_ERROR;
    end else begin
      ram_cnt++;
      if (ram_cnt >= lat) begin
        bus.ramstate = S_ACCESS;
        ram_cnt = 0;
      end else begin
        bus.ramstate = S_BUSY;
      end
    end
    bus.ramload = ram[bus.ramaddr[6:2]];
    if (bus.ramstate == S_ACCESS && bus.ramWEN) ram[bus.ramaddr[6:2]] = bus.ramstore;
  endtask

  task automatic step();
    int nlow;
    logic en;
    @(negedge CLK);
    ram_drive();
    #1;
    en = bus.ramREN | bus.ramWEN;
    check("ren_wen_excl", 32'(bus.ramREN & bus.ramWEN), 32'd0);
    nlow = 0;
    comp_who = -1;
    for (int i = 0; i < CPUS; i++) begin
      if (!bus.iwait[i]) begin
        nlow++;
        comp_who = i;
      end
    end
    if (!bus.dwait) begin
      nlow++;
      comp_who = DATA;
    end
    check("waits_low_vs_access", 32'(nlow), (en && bus.ramstate == S_ACCESS) ? 32'd1 : 32'd0);
    if (comp_who == DATA) comp_load = bus.dload;
    else if (comp_who >= 0) comp_load = bus.iload[comp_who];
    else comp_load = '0;
    comp_addr  = bus.ramaddr;
    comp_store = bus.ramstore;
  endtask

  task automatic wait_comp(input int max_cyc, output int who, output int cyc);
    cyc = 0;
    who = -1;
    while (who < 0 && cyc < max_cyc) begin
      step();
      cyc++;
      who = comp_who;
    end
    if (who < 0) check("completion_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_inputs();
    bus.iREN = '0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.ramstate = S_FREE; bus.ramload = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    clear_inputs();
    lat = 1; err_left = 0; ram_cnt = 0;
    @(negedge CLK);
    #1 nRST = 1'b1;
  endtask

  // transaction-level model state
  bit          i_act [CPUS];
  logic [31:0] i_adr [CPUS];
  bit          d_act;
  int          d_kind;
  logic [31:0] d_adr, d_val;
  int          m_rr, m_starve;

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 31)) << 2;
  endfunction

  task automatic apply_reqs();
    for (int i = 0; i < CPUS; i++) begin
      bus.iREN[i]  = i_act[i];
      bus.iaddr[i] = i_adr[i];
    end
    bus.dREN   = d_act && (d_kind != 1);
    bus.dWEN   = d_act && (d_kind != 0);
    bus.daddr  = d_adr;
    bus.dstore = d_val;
  endtask

  function automatic int predict();
    bit any_i;
    any_i = 1'b0;
    for (int i = 0; i < CPUS; i++) any_i |= i_act[i];
    if (d_act && (!any_i || m_starve < LIMIT)) return DATA;
    for (int k = 0; k < CPUS; k++) begin
      if (i_act[(m_rr + k) % CPUS]) return (m_rr + k) % CPUS;
    end
    return -1;
  endfunction

  task automatic new_data();
    d_kind = int'($urandom_range(0, 2));
    d_adr  = rand_addr();
    d_val  = $urandom;
  endtask

  initial begin
    int who, cyc, ndata, exp_who;
    logic [31:0] v;
    bit any_i;

    for (int k = 0; k < 32; k++) ram[k] = $urandom;
    clear_inputs();
    bus.iREN = 2'b11;
    bus.dREN = 1'b1;
    @(negedge CLK);
    #1;
    check("rst_iwait", 32'(bus.iwait), 32'h3);
    check("rst_dwait", 32'(bus.dwait), 32'd1);
    check("rst_ram_en", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
    check("rst_ramaddr", bus.ramaddr, 32'd0);
    check("rst_ramstore", bus.ramstore, 32'd0);
    check("rst_iload0", bus.iload[0], 32'd0);
    check("rst_iload1", bus.iload[1], 32'd0);
    check("rst_dload", bus.dload, 32'd0);

    // asynchronous reset during a fetch held BUSY
    do_reset();
    lat = 10;
    bus.iaddr[0] = 32'h10;
    bus.iREN = 2'b01;
    step();
    check("t1_ren_granted", 32'(bus.ramREN), 32'd1);
    nRST = 1'b0;
    #1;
    check("t1_ren_async", 32'(bus.ramREN), 32'd0);
    check("t1_iwait_async", 32'(bus.iwait), 32'h3);
    check("t1_ramaddr_async", bus.ramaddr, 32'd0);
    bus.iREN = 2'b00;
    nRST = 1'b1;
    step();
    check("t1_idle_after", 32'(bus.ramREN), 32'd0);

    // both fetchers held: alternate 0,1,0 at latency+1 cycles each
    do_reset();
    lat = 2;
    bus.iaddr[0] = 32'h10;
    bus.iaddr[1] = 32'h20;
    bus.iREN = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_comp(20, who, cyc);
      check("t2_grant", 32'(who), 32'(k % 2));
      check("t2_iload", comp_load, ram[(k % 2 == 0) ? 4 : 8]);
      if (k > 0) check("t2_period", 32'(cyc), 32'(lat + 1));
    end

    // write wins over a simultaneous fetch; the fetch follows and sees the new word
    do_reset();
    lat = 2;
    bus.dWEN = 1'b1; bus.daddr = 32'h40; bus.dstore = 32'hDEADBEEF;
    bus.iaddr[0] = 32'h40;
    bus.iREN = 2'b01;
    step();
    check("t3_ramWEN", 32'(bus.ramWEN), 32'd1);
    check("t3_ramREN", 32'(bus.ramREN), 32'd0);
    check("t3_ramaddr", bus.ramaddr, 32'h40);
    check("t3_ramstore", bus.ramstore, 32'hDEADBEEF);
    wait_comp(20, who, cyc);
    check("t3_data_first", 32'(who), 32'(DATA));
    bus.dWEN = 1'b0;
    wait_comp(20, who, cyc);
    check("t3_fetch_next", 32'(who), 32'd0);
    check("t3_fetch_gap", 32'(cyc), 32'(lat + 1));
    check("t3_fetch_data", comp_load, 32'hDEADBEEF);

    // starvation guard: LIMIT reads, then the waiting fetch, twice
    do_reset();
    lat = 1;
    bus.dREN = 1'b1; bus.daddr = 32'h08;
    bus.iaddr[1] = 32'h0C;
    bus.iREN = 2'b10;
    for (int r = 0; r < 2; r++) begin
      ndata = 0;
      forever begin
        wait_comp(20, who, cyc);
        if (who != DATA) break;
        check("t4_dload", comp_load, ram[2]);
        ndata++;
        if (ndata > 2 * LIMIT) break;
      end
      check("t4_data_before_fetch", 32'(ndata), 32'(LIMIT));
      check("t4_forced_core", 32'(who), 32'd1);
    end

    // fetch abort leaves the round-robin pointer alone
    do_reset();
    lat = 10;
    bus.iaddr[0] = 32'h14;
    bus.iREN = 2'b01;
    step();
    check("t5_ren_granted", 32'(bus.ramREN), 32'd1);
    bus.iREN = 2'b00;
    step();
    check("t5_ren_aborted", 32'(bus.ramREN), 32'd0);
    check("t5_iwait", 32'(bus.iwait), 32'h3);
    lat = 1;
    bus.iaddr[1] = 32'h18;
    bus.iREN = 2'b11;
    wait_comp(20, who, cyc);
    check("t5_rr_unchanged", 32'(who), 32'd0);

    // read+write acts as a write; ERROR cycles hold the grant
    do_reset();
    lat = 1;
    err_left = 3;
    v = $urandom;
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h44; bus.dstore = v;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t6_ramWEN", 32'(bus.ramWEN), 32'd1);
      check("t6_ramREN", 32'(bus.ramREN), 32'd0);
      check("t6_dwait_error", 32'(bus.dwait), 32'd1);
    end
    step();
    check("t6_dwait_access", 32'(bus.dwait), 32'd0);
    check("t6_written", ram[17], v);

    // randomized traffic against the transaction-level model
    do_reset();
    for (int k = 0; k < 32; k++) ref_mem[k] = ram[k];
    m_rr = 0;
    m_starve = 0;
    for (int i = 0; i < CPUS; i++) begin
      i_act[i] = ($urandom_range(0, 1) == 1);
      i_adr[i] = rand_addr();
    end
    d_act = 1'b1;
    new_data();
    apply_reqs();
    exp_who = predict();
    for (int t = 0; t < 300; t++) begin
      wait_comp(40, who, cyc);
      if (who < 0) break;
      check("rnd_who", 32'(who), 32'(exp_who));
      if (exp_who == DATA) begin
        check("rnd_daddr", comp_addr, d_adr);
        if (d_kind == 0) check("rnd_dload", comp_load, ref_mem[d_adr[6:2]]);
        else begin
          check("rnd_dstore", comp_store, d_val);
          ref_mem[d_adr[6:2]] = d_val;
        end
        d_act = ($urandom_range(0, 9) < 7);
        new_data();
      end else begin
        check("rnd_iaddr", comp_addr, i_adr[exp_who]);
        check("rnd_iload", comp_load, ref_mem[i_adr[exp_who][6:2]]);
        i_act[exp_who] = ($urandom_range(0, 9) < 7);
        i_adr[exp_who] = rand_addr();
      end
      for (int i = 0; i < CPUS; i++) begin
        if (!i_act[i] && $urandom_range(0, 9) < 3) begin
          i_act[i] = 1'b1;
          i_adr[i] = rand_addr();
        end
      end
      if (!d_act && $urandom_range(0, 9) < 3) d_act = 1'b1;
      any_i = 1'b0;
      for (int i = 0; i < CPUS; i++) any_i |= i_act[i];
      if (exp_who == DATA) m_starve = !any_i ? 0 : ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1);
      else begin
        m_rr = (exp_who + 1) % CPUS;
        m_starve = 0;
      end
      lat = int'($urandom_range(1, 3));
      err_left = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 2)) : 0;
      apply_reqs();
      if (!any_i && !d_act) begin
        step();
        check("rnd_idle", 32'(comp_who), 32'hFFFF_FFFF);
        i_act[$urandom_range(0, CPUS - 1)] = 1'b1;
        d_act = ($urandom_range(0, 1) == 1);
        apply_reqs();
      end
      exp_who = predict();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
